// File: rtl/hc283_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/sub built around one external 4-bit ripple adder.
// Operands are fed one nibble per clock, LSB first; cout is registered and rippled.
module hc283_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last;
  logic             c3;

  assign last = (idx_q == IW'(NIB - 1));
  // Carry into the adder's MSB, recovered from its inputs and sum bit.
  assign c3   = add_a[3] ^ add_b[3] ^ add_sum[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*4 +: 4] = add_sum;
        carry_d                = add_cout;
        if (last) begin
          cout_d  = add_cout;
          ovf_d   = c3 ^ add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign add_a    = busy ? a_q[idx_q*4 +: 4] : 4'h0;
  assign add_b    = busy ? b_q[idx_q*4 +: 4] : 4'h0;
  assign add_cin  = busy ? carry_q : 1'b0;
endmodule

// File: tb/tb_hc283_nibble_sequencer.sv
// Directed bench for hc283_nibble_sequencer with a behavioural 74HC283 model.
module tb_hc283_nibble_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy, done, cout, overflow, add_cin, add_cout;
  logic [15:0] result;
  logic [3:0]  add_a, add_b, add_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External 4-bit adder stage.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  hc283_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] aseq, bseq;
  logic [3:0]  cseq;
  int          ncyc;

  // Issue one op at a negedge, record adder drive per RUN cycle; returns at first non-busy negedge.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b; cin = c;
    @(negedge clk);
    start = 1'b0;
    aseq = '0; bseq = '0; cseq = '0; ncyc = 0;
    for (int k = 0; k < 10 && busy; k++) begin
      if (k < 4) begin
        aseq[k*4 +: 4] = add_a;
        bseq[k*4 +: 4] = add_b;
        cseq[k]        = add_cin;
      end
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_done(input string tag, input logic [15:0] r, input logic co, input logic ov);
    chk({tag, ".busy_cycles"}, ncyc, 4);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".cout"}, cout, co);
    chk({tag, ".overflow"}, overflow, ov);
  endtask

  initial begin
    #2;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", {cout, overflow}, 0);
    chk("rst.adder_drive", {add_a, add_b, add_cin}, 0);
    #10 rst_n = 1'b1;

    run_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    chk("add1.add_a_seq", aseq, 16'h1234);
    chk_done("add1", 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    chk("add1.done_pulse_one_cycle", done, 0);
    chk("idle.adder_drive", {add_a, add_b, add_cin}, 0);

    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    chk("add2.add_cin_seq", cseq, 4'b1110);
    chk_done("add2", 16'h0000, 1'b1, 1'b0);

    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk_done("add3", 16'h8000, 1'b0, 1'b1);

    run_op(1'b1, 16'h0005, 16'h0007, 1'b1);
    chk("sub1.add_b_nib0", bseq[3:0], 4'h8);
    chk("sub1.add_cin_nib0", cseq[0], 1'b1);
    chk_done("sub1", 16'hFFFE, 1'b0, 1'b0);

    run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    chk_done("sub2", 16'h7FFF, 1'b1, 1'b1);

    // Reset during the 2nd RUN cycle.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid.busy_before", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.result", result, 0);
    chk("rstmid.flags", {cout, overflow}, 0);
    chk("rstmid.adder_drive", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ncyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) ncyc++;
    end
    chk("rstmid.no_done_after", ncyc, 0);
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0);
    chk_done("postrst", 16'h0002, 1'b0, 1'b0);

    // start held through RUN and DONE; operands change mid-RUN.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'h5555;
    ncyc = 0;
    for (int k = 0; k < 10 && busy; k++) begin
      ncyc++;
      @(negedge clk);
    end
    chk_done("hold", 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold.idle_after_done", {busy, done}, 2'b00);
    @(negedge clk);
    chk("hold.restart_from_idle", busy, 1);
    start = 1'b0;
    ncyc = 1;
    @(negedge clk);
    for (int k = 0; k < 10 && busy; k++) begin
      ncyc++;
      @(negedge clk);
    end
    chk_done("hold2", 16'hFFFF, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hc283_nibble_sequencer.md
Name: hc283_nibble_sequencer

Overview:
- Multi-cycle wide adder/subtractor controller that time-multiplexes one external 4-bit combinational adder stage (74HC283-style: a[3:0], b[3:0], cin in; sum[3:0], cout out).
- Sits directly around that adder. It feeds the adder one operand nibble per clock, LSB first, and registers the adder's sum and cout each cycle. The registered cout becomes the next nibble's carry-in (ripple carry across clock cycles).
- Provides a start/busy/done handshake to the upstream controller.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibbles (derived; not overridable).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  sampled with start; 1 = compute op_a - op_b.
- op_a  input  WIDTH  operand A, sampled with start.
- op_b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add, sampled with start; ignored when sub=1.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse; result/cout/overflow valid.
- result  output  WIDTH  registered sum/difference; held until next start.
- cout  output  1  final carry-out. For sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the full-width operation.
- add_a  output  4  nibble of A to the adder.
- add_b  output  4  nibble of B (inverted when sub) to the adder.
- add_cin  output  1  carry-in to the adder.
- add_sum  input  4  adder sum, combinational response to add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, result, cout, overflow, the carry register and the nibble index are all 0.
  - add_a, add_b and add_cin are 0.
  - Takes effect immediately, including mid-RUN. The partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0. Adder drive outputs are 0.
  - start=1 at a rising edge:
    - latch op_a into A_r.
    - latch op_b into B_r (B_r = ~op_b when sub=1).
    - carry register <= (sub ? 1 : cin).
    - clear index to 0; go to RUN.
  - result, cout and overflow keep their previous values until overwritten.
- RUN:
  - busy=1.
  - add_a = A_r nibble[index], add_b = B_r nibble[index], add_cin = carry register.
  - At each rising edge:
    - result nibble[index] <= add_sum.
    - carry register <= add_cout.
    - index increments.
  - At the edge where index = NIB-1:
    - cout <= add_cout.
    - overflow <= carry into bit 3 XOR add_cout, where carry into bit 3 = add_a[3] ^ add_b[3] ^ add_sum[3].
    - go to DONE.
  - start is ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle; then go to IDLE.
  - start in DONE is ignored. Back-to-back operations need start in the following IDLE cycle.
- Latency:
  - start sampled at edge E0; result final after edge E(NIB).
  - done is high during the cycle after E(NIB).
  - Next start can be accepted at E(NIB+2).
- Outputs are registered except add_a/add_b/add_cin, which are decoded from registered state only.
- Arithmetic is modulo 2^WIDTH. No saturation.
- The index counts 0..NIB-1 and never wraps beyond NIB-1 in RUN.

Test Plan:
- WIDTH=16, add, 0x1234+0x4321, cin=0 -> busy high 4 cycles; add_a sequence 4,3,2,1; then done pulse; result=0x5555, cout=0, overflow=0.
- Add 0xFFFF+0x0001, cin=0 -> result=0x0000, cout=1, overflow=0. add_cin sequence 0,1,1,1 confirms the carry ripples across cycles.
- Add 0x7FFF+0x0001 -> result=0x8000, cout=0, overflow=1.
- Sub 0x0005-0x0007, cin=1 (ignored) -> add_b first nibble=0x8, add_cin first=1; result=0xFFFE, cout=0 (borrow), overflow=0.
- Sub 0x8000-0x0001 -> result=0x7FFF, cout=1, overflow=1.
- Reset and handshake:
  - Pulse rst_n low during the 2nd RUN cycle -> all outputs 0 immediately; no done; next start 0x0001+0x0001 -> result=0x0002.
  - start held high through RUN and DONE -> ignored; the next op begins only from IDLE, and operands applied mid-RUN do not corrupt the result.
